// File: rtl/float_div_pipeline.sv
// float_div_pipeline: multi-cycle single-precision divider, out = a / b.
// Restoring division producing one quotient bit per cycle, then a single
// normalise/clamp cycle. Operands with exp==0 are treated as zero, the
// mantissa is truncated, and the req/ack handshake matches the multiplier.
module float_div_pipeline #(
  parameter int float_width      = 32,
  parameter int float_exp_width  = 8,
  parameter int float_mant_width = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  output logic                   ack,
  input  logic [float_width-1:0] a,
  input  logic [float_width-1:0] b,
  output logic [float_width-1:0] out
);

  localparam int EW = float_exp_width;
  localparam int MW = float_mant_width;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_t;

  // Exponent arithmetic runs two bits wider and signed so that overflow
  // above the all-ones exponent and underflow below zero are both visible.
  localparam logic signed [EW+1:0] BIAS_E  = {3'b000, {(EW-1){1'b1}}};
  localparam logic signed [EW+1:0] EMAX_E  = {2'b00, {EW{1'b1}}};
  localparam logic signed [EW+1:0] ZERO_E  = {(EW+2){1'b0}};
  localparam logic signed [EW+1:0] ONE_E   = {{(EW+1){1'b0}}, 1'b1};
  localparam logic [4:0]           POS_LAST = 5'(MW + 1);

  state_t                  state_r;
  logic [4:0]              pos_r;
  logic [MW+1:0]           rem_r;   // partial remainder, < 2*mb
  logic [MW:0]             mb_r;    // divisor with hidden one
  logic [MW+1:0]           q_r;     // quotient, MSB first via shift-in
  logic signed [EW+1:0]    exp_r;
  logic                    sign_r;

  logic                    a_zero_s;
  logic                    b_zero_s;
  logic                    sign_s;
  logic signed [EW+1:0]    exp_calc_s;
  logic                    rem_ge_s;
  logic [MW+1:0]           rem_sub_s;
  logic [MW-1:0]           mant_norm_s;
  logic signed [EW+1:0]    exp_norm_s;
  logic [float_width-1:0]  result_s;

  assign a_zero_s   = (a[float_width-2 -: EW] == {EW{1'b0}});
  assign b_zero_s   = (b[float_width-2 -: EW] == {EW{1'b0}});
  assign sign_s     = a[float_width-1] ^ b[float_width-1];
  assign exp_calc_s = $signed({2'b00, a[float_width-2 -: EW]})
                    - $signed({2'b00, b[float_width-2 -: EW]}) + BIAS_E;
  assign rem_ge_s   = (rem_r >= {1'b0, mb_r});
  assign rem_sub_s  = rem_r - {1'b0, mb_r};

  // Normalise the finished quotient and clamp the exponent into range.
  always_comb begin
    mant_norm_s = {MW{1'b0}};
    exp_norm_s  = exp_r;
    result_s    = {float_width{1'b0}};
    if (q_r[MW+1]) begin
      mant_norm_s = q_r[MW:1];
      exp_norm_s  = exp_r;
    end else begin
      mant_norm_s = q_r[MW-1:0];
      exp_norm_s  = exp_r - ONE_E;
    end
    if (exp_norm_s >= EMAX_E) begin
      result_s = {sign_r, {EW{1'b1}}, {MW{1'b0}}};
    end else if (exp_norm_s <= ZERO_E) begin
      result_s = {float_width{1'b0}};
    end else begin
      result_s = {sign_r, exp_norm_s[EW-1:0], mant_norm_s};
    end
  end

  // Control FSM with registered ack/out; ack pulses for one cycle only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      pos_r   <= 5'd0;
      rem_r   <= {(MW+2){1'b0}};
      mb_r    <= {(MW+1){1'b0}};
      q_r     <= {(MW+2){1'b0}};
      exp_r   <= ZERO_E;
      sign_r  <= 1'b0;
      ack     <= 1'b0;
      out     <= {float_width{1'b0}};
    end else begin
      ack <= 1'b0;
      out <= {float_width{1'b0}};
      case (state_r)
        IDLE: begin
          if (req) begin
            if (a_zero_s) begin
              ack <= 1'b1;
              out <= {float_width{1'b0}};
            end else if (b_zero_s) begin
              ack <= 1'b1;
              out <= {sign_s, {EW{1'b1}}, {MW{1'b0}}};
            end else begin
              rem_r   <= {2'b01, a[MW-1:0]};
              mb_r    <= {1'b1, b[MW-1:0]};
              q_r     <= {(MW+2){1'b0}};
              exp_r   <= exp_calc_s;
              sign_r  <= sign_s;
              pos_r   <= 5'd0;
              state_r <= DIV;
            end
          end
        end
        DIV: begin
          if (rem_ge_s) begin
            q_r   <= {q_r[MW:0], 1'b1};
            rem_r <= {rem_sub_s[MW:0], 1'b0};
          end else begin
            q_r   <= {q_r[MW:0], 1'b0};
            rem_r <= {rem_r[MW:0], 1'b0};
          end
          pos_r <= pos_r + 5'd1;
          if (pos_r == POS_LAST) begin
            state_r <= NORM;
          end
        end
        NORM: begin
          ack     <= 1'b1;
          out     <= result_s;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_div_pipeline.sv
// Directed self-checking bench for float_div_pipeline.
module tb_float_div_pipeline;

  logic        clk;
  logic        rst;
  logic        req;
  logic        ack;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out;

  int n_cmp = 0;
  int n_err = 0;

  float_div_pipeline dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .ack (ack),
    .a   (a),
    .b   (b),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one normal division, expect ack exactly 26 edges after sampling.
  task automatic run_normal(input string name, input logic [31:0] va,
                            input logic [31:0] vb, input logic [31:0] exp_out);
    int lat;
    @(negedge clk);
    a = va; b = vb; req = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b0 || out !== 32'h0) begin
      n_err++;
      $display("FAIL %s_busy_after_E: ack=%b out=%h, required ack=0 out=00000000", name, ack, out);
    end
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack === 1'b1) lat--;
      if (ack === 1'b1) break;
    end
    n_cmp++;
    if (lat !== 26) begin
      n_err++;
      $display("FAIL %s_latency: got %0d edges, required 26", name, lat);
    end
    n_cmp++;
    if (out !== exp_out) begin
      n_err++;
      $display("FAIL %s_out: got %h, required %h", name, out, exp_out);
    end
  endtask

  // Special operand: ack and result already at the sampling edge.
  task automatic run_special(input string name, input logic [31:0] va,
                             input logic [31:0] vb, input logic [31:0] exp_out);
    @(negedge clk);
    a = va; b = vb; req = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b1 || out !== exp_out) begin
      n_err++;
      $display("FAIL %s_at_E: ack=%b out=%h, required ack=1 out=%h", name, ack, out, exp_out);
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ack !== 1'b0 || out !== 32'h0) begin
      n_err++;
      $display("FAIL %s_drop: ack=%b out=%h, required ack=0 out=00000000", name, ack, out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (ack !== 1'b0 || out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: ack=%b out=%h, required ack=0 out=00000000", ack, out);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ack !== 1'b0 || out !== 32'h0) begin
      n_err++;
      $display("FAIL idle_no_req: ack=%b out=%h, required ack=0 out=00000000", ack, out);
    end
  endtask

  task automatic test_normal();
    run_normal("div_6_2",   32'h40C00000, 32'h40000000, 32'h40400000);
    run_normal("div_1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    run_normal("div_m8_05", 32'hC1000000, 32'h3F000000, 32'hC1800000);
  endtask

  task automatic test_zero();
    run_special("zero_num",  32'h00000000, 32'h40A00000, 32'h00000000);
    run_special("zero_den",  32'h40A00000, 32'h00000000, 32'h7F800000);
    run_special("zero_den_neg", 32'hC0A00000, 32'h00000000, 32'hFF800000);
    run_special("zero_zero", 32'h00000000, 32'h00000000, 32'h00000000);
  endtask

  task automatic test_clamp();
    run_normal("overflow",  32'h7F000000, 32'h00800000, 32'h7F800000);
    run_normal("underflow", 32'h00800000, 32'h7F000000, 32'h00000000);
  endtask

  // A req pulse (with zero operands) during DIV must not produce a second ack.
  task automatic test_busy();
    int acks;
    int first;
    acks = 0; first = 0;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        a = 32'h00000000; b = 32'h40A00000; req = 1'b1;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        acks++;
        if (first == 0) first = i;
      end
      @(negedge clk);
    end
    req = 1'b0;
    n_cmp++;
    if (acks !== 1 || first !== 26) begin
      n_err++;
      $display("FAIL busy_req_ignored: acks=%0d first=%0d, required acks=1 first=26", acks, first);
    end
  endtask

  // Reset mid-division: the transaction is dropped, the next one works.
  task automatic test_abort();
    int acks;
    acks = 0;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ack !== 1'b0 || out !== 32'h0) begin
      n_err++;
      $display("FAIL abort_in_reset: ack=%b out=%h, required ack=0 out=00000000", ack, out);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_err++;
      $display("FAIL abort_no_ack: acks=%0d, required 0", acks);
    end
    run_normal("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000);
  endtask

  // New request sampled on the edge right after the ack pulse is registered.
  task automatic test_back_to_back();
    run_normal("b2b_first",  32'hC1000000, 32'h3F000000, 32'hC1800000);
    run_normal("b2b_second", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero();
    test_clamp();
    test_busy();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
